// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes and default datapath width (shared by alu_seq and alu_shift_unit)
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_BEQ = 4'b1000,
    OP_SLT = 4'b1100,
    OP_JAL = 4'b1101
  } alu_op_e;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// rtl/alu_shift_unit.sv - shift datapath: iterative one-bit-per-cycle, or barrel with ALU_SEQ_BARREL_SHIFT_EN
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_load,
  input  alu_op_e                  i_op,
  input  logic [WIDTH-1:0]         i_a,
  input  logic [$clog2(WIDTH)-1:0] i_amt,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_last
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_data;

  assign o_data = r_data;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] d,
                                              input logic [SHW-1:0] amt,
                                              input alu_op_e op);
    case (op)
      OP_SLL:  return d << amt;
      OP_SRA:  return $unsigned($signed(d) >>> amt);
      default: return d >> amt;
    endcase
  endfunction

  // Whole shift is resolved in the accept cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= barrel(i_a, i_amt, i_op);
    end
  end

  assign o_last = 1'b0;
`else
  logic [SHW-1:0] r_cnt;
  alu_op_e        r_op;

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input alu_op_e op);
    case (op)
      OP_SLL:  return {d[WIDTH-2:0], 1'b0};
      OP_SRA:  return {d[WIDTH-1], d[WIDTH-1:1]};
      default: return {1'b0, d[WIDTH-1:1]};
    endcase
  endfunction

  // First step happens on the accept edge so an N-bit shift finishes N cycles later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_op   <= OP_SLL;
    end else if (i_load) begin
      r_data <= step(i_a, i_op);
      r_cnt  <= i_amt - 1'b1;
      r_op   <= i_op;
    end else if (r_cnt != '0) begin
      r_data <= step(r_data, r_op);
      r_cnt  <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == SHW'(1));
`endif

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake; ALU_SEQ_BARREL_SHIFT_EN selects single-cycle shifts
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           r_state;
  state_e           w_next;
  alu_op_e          w_op;
  logic [SHW-1:0]   w_amt;
  logic             w_accept;
  logic             w_use_shift;
  logic             w_shift_last;
  logic [WIDTH-1:0] w_alu_result;
  logic [WIDTH-1:0] w_shift_data;
  logic             w_branch;
  logic [WIDTH-1:0] r_result;
  logic             r_branch;
  logic             r_from_shift;

  assign w_op        = alu_op_e'(operation);
  assign w_amt       = b[SHW-1:0];
  assign w_use_shift = is_shift_op(w_op) && (w_amt != '0);
  assign w_accept    = in_valid && (r_state == IDLE);

  // Single-cycle result for every op that does not need the shift unit.
  always_comb begin
    w_alu_result = '0;
    w_branch     = 1'b0;
    case (w_op)
      OP_AND: w_alu_result = a & b;
      OP_OR:  w_alu_result = a | b;
      OP_ADD: w_alu_result = a + b;
      OP_XOR: w_alu_result = a ^ b;
      OP_SUB: w_alu_result = a - b;
      OP_BEQ: w_branch     = (a == b);
      OP_SLT: w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_JAL: w_alu_result = a + WIDTH'(4);
      OP_SLL, OP_SRL, OP_SRA: w_alu_result = a;  // zero shift amount passes a through
      default: ;
    endcase
  end

  alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept && w_use_shift),
    .i_op   (w_op),
    .i_a    (a),
    .i_amt  (w_amt),
    .o_data (w_shift_data),
    .o_last (w_shift_last)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef ALU_SEQ_BARREL_SHIFT_EN
          w_next = DONE;
`else
          w_next = (w_use_shift && (w_amt > SHW'(1))) ? SHIFT : DONE;
`endif
        end
      end
      SHIFT: if (w_shift_last) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Capture the decoded result on accept so later input changes cannot disturb it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result     <= '0;
      r_branch     <= 1'b0;
      r_from_shift <= 1'b0;
    end else if (w_accept) begin
      r_result     <= w_alu_result;
      r_branch     <= w_branch;
      r_from_shift <= w_use_shift;
    end
  end

  assign result       = r_from_shift ? w_shift_data : r_result;
  assign branch_taken = r_branch;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the datapath width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port operation, input, 4 bits: the op code produced by the ALU controller.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B; shift amount is b[$clog2(WIDTH)-1:0].
REQ-009 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port result, output, WIDTH bits: the operation result.
REQ-012 The block SHALL have port branch_taken, output, 1 bit: the branch-compare outcome.

Function
REQ-013 Op codes SHALL be decoded as follows:
- 0000 AND
- 0001 OR
- 0010 ADD
- 0011 XOR
- 0100 SLL
- 0101 SRL
- 0110 SUB
- 0111 SRA
- 1000 BEQ: result 0, branch_taken = (a==b)
- 1100 SLT, signed: result = {0..., a<b}
- 1101 JAL: result = a+4
- any other code: result 0, branch_taken 0
REQ-014 branch_taken SHALL be 0 for every op except BEQ.
REQ-015 ADD, SUB and JAL SHALL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-016 The FSM states SHALL be IDLE, SHIFT and DONE, with in_ready = (state==IDLE).
REQ-017 On an accept (in_valid && in_ready), the block SHALL capture operation, a and b.
REQ-018 After an accept, a non-shift op SHALL go IDLE->DONE, with out_valid asserted the next cycle.
REQ-019 After an accept, a shift op with amount N>0 SHALL go IDLE->SHIFT, shift one bit per cycle, and go SHIFT->DONE after N cycles; out_valid SHALL be asserted N cycles after the accept.
REQ-020 A shift op with amount 0 SHALL behave as a non-shift op: latency 1, result = a.
REQ-021 SRA SHALL replicate a[WIDTH-1] on every step; SRL and SLL SHALL fill with 0.
REQ-022 In DONE, result, branch_taken and out_valid SHALL be held stable until out_ready; DONE->IDLE occurs on out_valid && out_ready.
REQ-023 in_ready SHALL be 0 in SHIFT and DONE; requests presented then SHALL be ignored and not captured.
REQ-024 Input changes after the accept SHALL NOT affect the in-flight result.
REQ-025 Back-to-back throughput SHALL be one op per 2 cycles minimum (accept, then DONE handoff); in_ready SHALL rise the cycle after the handoff.

Reset
REQ-026 When reset is sampled high, the state SHALL become IDLE, with out_valid=0, result=0 and branch_taken=0.
REQ-027 in_ready SHALL be 1 in the first cycle after reset is released.
REQ-028 A reset during SHIFT or DONE SHALL discard the in-flight op; no out_valid SHALL follow.
REQ-029 Reset SHALL take priority over a simultaneous in_valid.

Configuration
REQ-030 With ALU_SEQ_BARREL_SHIFT_EN defined, shifts SHALL use a single-cycle barrel shifter: every op has latency 1, and SHIFT is never entered.
REQ-031 Without ALU_SEQ_BARREL_SHIFT_EN, the iterative shifting of REQ-019 to REQ-021 SHALL apply.
REQ-032 Functional results SHALL be identical with and without ALU_SEQ_BARREL_SHIFT_EN; only latency differs.

Structure
REQ-033 Package alu_pkg SHALL hold the 4-bit op-code typedef enum (the REQ-013 values) and the default WIDTH constant.
REQ-034 The ALU controller and alu_seq SHALL both import alu_pkg.
REQ-035 Sub-module alu_shift_unit SHALL contain the shift datapath: the iterative shift-register plus step counter, or the barrel shifter under ALU_SEQ_BARREL_SHIFT_EN.
REQ-036 The op decode, FSM and handshake SHALL remain in alu_seq.

Verification
REQ-037 The bench SHALL send ADD a=0xFFFFFFFF, b=1 -> result 0x00000000, out_valid 1 cycle after the accept.
REQ-038 The bench SHALL send SRA a=0x80000000, b=4 -> result 0xF8000000, out_valid 4 cycles after the accept (1 cycle with the macro).
REQ-039 The bench SHALL send SLT a=0xFFFFFFFF, b=1 -> result 1; then BEQ a=b=0x1234 -> branch_taken 1 and result 0.
REQ-040 The bench SHALL hold out_ready=0 for 5 cycles after a XOR result -> result and out_valid are stable, in_ready is 0, and a second in_valid is not captured.
REQ-041 The bench SHALL assert reset in the 3rd cycle of SLL b=10 -> out_valid never rises, and in_ready=1 the cycle after release.
REQ-042 The bench SHALL send SLL with b=32 (shift field 0) and unused op 1111 -> result a and result 0 respectively, each with latency 1.
